jedro_1_ifu: RTL and testbench
==============================

# jedro_1_ifu

Instruction fetch unit for the riscv-jedro-1 core. It holds the fetch program counter and issues word requests to instruction memory over a request/grant/rvalid handshake. Returned words are buffered in a 2-entry prefetch FIFO and handed to the decoder through the `instr_next_avail`/`instr_next_en` handshake. Jumps and branches redirect the PC, flush the buffer and squash any in-flight response.

## Interface
- `DATA_WIDTH`, 32, instruction and address width
- `BOOT_ADDR`, 32'h0000_0000, fetch PC after reset; bits [1:0] must be 0
- `clk_i`  in  1  single clock; all state updates on rising edge
- `rstn_i`  in  1  reset, asynchronous and active-low
- `jmp_addr_i`  in  DATA_WIDTH  redirect target
- `jmp_addr_valid_i`  in  1  redirect strobe, one cycle per redirect
- `imem_req_o`  out  1  fetch request
- `imem_addr_o`  out  DATA_WIDTH  word address of the request
- `imem_gnt_i`  in  1  request accepted; the handshake completes when `imem_req_o` and `imem_gnt_i` are both high
- `imem_rvalid_i`  in  1  read data valid, in order, ≥1 cycle after grant
- `imem_rdata_i`  in  DATA_WIDTH  read data
- `instr_rdata_o`  out  DATA_WIDTH  instruction at FIFO head
- `instr_addr_o`  out  DATA_WIDTH  PC of the FIFO-head instruction
- `instr_next_avail_o`  out  1  FIFO non-empty
- `instr_next_en_i`  in  1  decoder pops the head; ignored when the FIFO is empty

## Operation
- Registers:
  - `fetch_pc`
  - FIFO: 2 entries of {addr, instr}, rd/wr pointers, 2-bit count
  - FSM
- Fetch PC:
  - `fetch_pc += 4` on each grant (wraps modulo 2^32).
  - Redirect loads `jmp_addr_i` with bits [1:0] forced to 0.
- FSM states:
  - S_REQ: `imem_req_o = (count < 2)`, `imem_addr_o = fetch_pc`.
    - grant and no redirect → S_WAIT.
    - grant and redirect in the same cycle → S_DROP (the granted word belongs to the old stream).
    - redirect without grant → stay in S_REQ with the new PC.
  - S_WAIT: `imem_req_o = 0`; exactly one response outstanding.
    - rvalid and no redirect → push {addr of request, rdata}, go to S_REQ.
    - rvalid and redirect → discard the word, go to S_REQ.
    - redirect without rvalid → S_DROP.
  - S_DROP: `imem_req_o = 0`. On rvalid, discard the data and go to S_REQ. A further redirect here only updates `fetch_pc`.
- At most one outstanding request at any time.
- FIFO:
  - Push occurs only from S_WAIT on rvalid without a redirect.
  - Pop occurs when `instr_next_avail_o & instr_next_en_i`.
  - Simultaneous push and pop is legal; count is unchanged.
  - Push can never see a full FIFO, because a request is issued only when count < 2 and count cannot grow while a response is outstanding.
- Redirect:
  - Clears the FIFO (count = 0, pointers = 0) in the same edge.
  - A pop in the same cycle is ignored.
  - `instr_next_avail_o` is 0 the following cycle.
- Address tracking: the PC of the outstanding request is held in a register, captured on grant, and pushed alongside the data.

## Timing
- Reset values:
  - `fetch_pc = BOOT_ADDR`, state S_REQ, count 0.
  - `imem_addr_o = BOOT_ADDR`.
  - `instr_next_avail_o = 0`.
  - `instr_rdata_o = 0`, `instr_addr_o = 0`.
- `imem_req_o` is 1 in the first cycle after reset deassertion (count 0). During reset it is 0.
- Reset assertion mid-transaction clears all state immediately. A late rvalid after reset, in S_REQ, is ignored.
- Latency with zero-wait memory (grant in cycle N, rvalid in N+1): `instr_next_avail_o` goes high in N+2 with `instr_rdata_o` valid.
- Peak throughput: one instruction per 2 cycles. The next request is asserted in the cycle after rvalid.
- `imem_addr_o` is stable while `imem_req_o` is high and no redirect occurs. A redirect may change the address of an ungranted request.
- `instr_next_avail_o`, `instr_rdata_o` and `instr_addr_o` are driven from registered FIFO state only, with no combinational path from `instr_next_en_i`. `imem_req_o` depends on state and count only.

## Test plan
- Reset release with `BOOT_ADDR` = 0x100, grant every cycle, rvalid one cycle after grant:
  - Requests go to 0x100, 0x104, 0x108.
  - The decoder sees those instructions in order with matching `instr_addr_o`.
  - First `instr_next_avail_o` appears 2 cycles after the first grant.
- Decoder holds `instr_next_en_i` = 0:
  - After 2 pushes, count = 2 and `imem_req_o` stays 0.
  - A single pop re-asserts `imem_req_o` the next cycle.
- Redirect to 0x2003 while in S_WAIT; the late rvalid carries 0xDEADBEEF:
  - That word is discarded and the FIFO is flushed.
  - The next request is to 0x2000 and the next delivered `instr_addr_o` = 0x2000.
- Redirect in the same cycle as a grant for 0x40:
  - The response for 0x40 is dropped (S_DROP).
  - No instruction with addr 0x40 reaches the decoder; fetch resumes at the target.
- Simultaneous push and pop at count = 1: count stays 1 and the order is preserved across 6 instructions.
- Assert `rstn_i` while a request is outstanding, then release:
  - Outputs reach their reset values asynchronously.
  - A stray rvalid after release is ignored and fetch restarts at `BOOT_ADDR`.

Source files
------------

// File: rtl/jedro_1_ifu_if.sv
// Instruction-memory request/grant/rvalid bus between the fetch unit (master)
// and instruction memory (slave).
interface jedro_1_ifu_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  req;
  logic [DATA_WIDTH-1:0] addr;
  logic                  gnt;
  logic                  rvalid;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (output req, addr, input  gnt, rvalid, rdata);
  modport slave  (input  req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/jedro_1_ifu.sv
// Fetch unit: owns the fetch PC, keeps one imem request in flight and buffers
// returned words in a 2-entry prefetch FIFO for the decoder.
module jedro_1_ifu #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] BOOT_ADDR  = '0
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic [DATA_WIDTH-1:0] jmp_addr_i,
  input  logic                  jmp_addr_valid_i,
  jedro_1_ifu_if.master         imem,
  output logic [DATA_WIDTH-1:0] instr_rdata_o,
  output logic [DATA_WIDTH-1:0] instr_addr_o,
  output logic                  instr_next_avail_o,
  input  logic                  instr_next_en_i
);

  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] instr;
  } fifo_entry_t;

  logic [1:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [DATA_WIDTH-1:0] req_addr_q, req_addr_d;
  fifo_entry_t [1:0]     fifo_q, fifo_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic                  wr_ptr_q, wr_ptr_d;
  logic [1:0]            count_q, count_d;

  logic redirect, req, gnt_hs, push, pop;

  assign redirect = jmp_addr_valid_i;
  // Reset gates the request so memory never sees one while rstn_i is low.
  assign req      = rstn_i & (state_q == S_REQ) & (count_q < 2'd2);
  assign gnt_hs   = req & imem.gnt;
  assign push     = (state_q == S_WAIT) & imem.rvalid & ~redirect;
  assign pop      = instr_next_avail_o & instr_next_en_i & ~redirect;

  assign imem.req           = req;
  assign imem.addr          = fetch_pc_q;
  assign instr_next_avail_o = (count_q != 2'd0);
  assign instr_rdata_o      = fifo_q[rd_ptr_q].instr;
  assign instr_addr_o       = fifo_q[rd_ptr_q].addr;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    req_addr_d = req_addr_q;
    state_d    = state_q;
    if (gnt_hs) begin
      fetch_pc_d = fetch_pc_q + DATA_WIDTH'(4);
      req_addr_d = fetch_pc_q;
    end
    if (redirect) fetch_pc_d = {jmp_addr_i[DATA_WIDTH-1:2], 2'b00};

    case (state_q)
      // A grant coinciding with a redirect fetches a word of the old stream.
      S_REQ:   if (gnt_hs) state_d = redirect ? S_DROP : S_WAIT;
      S_WAIT:  if (imem.rvalid) state_d = S_REQ;
               else if (redirect) state_d = S_DROP;
      S_DROP:  if (imem.rvalid) state_d = S_REQ;
      default: state_d = S_REQ;
    endcase
  end

  always_comb begin
    fifo_d   = fifo_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (redirect) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      // Never full on push: requests stop at count 2 and only one is in flight.
      if (push) begin
        fifo_d[wr_ptr_q].addr  = req_addr_q;
        fifo_d[wr_ptr_q].instr = imem.rdata;
        wr_ptr_d               = ~wr_ptr_q;
      end
      if (pop) rd_ptr_d = ~rd_ptr_q;
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= S_REQ;
      fetch_pc_q <= BOOT_ADDR;
      req_addr_q <= '0;
      fifo_q     <= '0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
      fifo_q     <= fifo_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

endmodule

// File: tb/tb_jedro_1_ifu.sv
// Bench for jedro_1_ifu: a stream-level model of what the decoder must see,
// a latency-programmable memory, and directed scenarios with literal checks.
module tb_jedro_1_ifu;
  localparam int          DW   = 32;
  localparam logic [31:0] BOOT = 32'h100;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] jmp_addr;
  logic        jmp_valid;
  logic [31:0] instr_rdata, instr_addr;
  logic        avail;
  logic        en_reg, en_follow, dec_en, gnt_reg;
  int          rv_lat;
  logic [31:0] poison_addr;

  jedro_1_ifu_if #(.DATA_WIDTH(DW)) imem ();

  assign imem.gnt = gnt_reg;
  assign dec_en   = en_follow ? imem.rvalid : en_reg;

  jedro_1_ifu #(.DATA_WIDTH(DW), .BOOT_ADDR(BOOT)) dut (
    .clk_i              (clk),
    .rstn_i             (rstn),
    .jmp_addr_i         (jmp_addr),
    .jmp_addr_valid_i   (jmp_valid),
    .imem               (imem),
    .instr_rdata_o      (instr_rdata),
    .instr_addr_o       (instr_addr),
    .instr_next_avail_o (avail),
    .instr_next_en_i    (dec_en)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == poison_addr) ? 32'hDEADBEEF : (a ^ 32'hC0DE_0000);
  endfunction

  // Model: the decoder sees, in order, every word whose request was granted and
  // answered with no redirect in between; a redirect discards everything queued.
  typedef struct { logic [31:0] addr; logic [31:0] data; } ent_t;
  ent_t        q[$];
  logic [31:0] m_pc = BOOT;
  bit          m_out = 0, m_live = 0;
  logic [31:0] m_out_addr = '0;

  bit          mem_pend = 0, rv_next = 0;
  int          mem_cnt = 0;
  logic [31:0] mem_addr = '0, rd_next = '0;

  always @(negedge clk) begin
    bit hs, redir, pop;
    hs = 0;
    if (!rstn) begin
      q.delete(); m_pc = BOOT; m_out = 0; m_live = 0;
      chk("rst_req", imem.req, 0);
      chk("rst_avail", avail, 0);
      chk("rst_pc", imem.addr, BOOT);
      chk("rst_rdata", instr_rdata, 0);
      chk("rst_iaddr", instr_addr, 0);
    end else begin
      chk("avail", avail, q.size() != 0);
      if (q.size() != 0) begin
        chk("head_addr", instr_addr, q[0].addr);
        chk("head_data", instr_rdata, q[0].data);
      end
      chk("req", imem.req, !m_out && q.size() < 2);
      if (imem.req) chk("req_addr", imem.addr, m_pc);
      redir = jmp_valid;
      hs    = imem.req && imem.gnt;
      pop   = avail && dec_en && !redir;
      if (pop && q.size() != 0) void'(q.pop_front());
      if (imem.rvalid && m_out) begin
        if (m_live && !redir) q.push_back('{m_out_addr, imem.rdata});
        m_out = 0;
      end
      if (hs) begin m_out = 1; m_out_addr = m_pc; m_live = !redir; m_pc += 4; end
      if (redir) begin q.delete(); m_live = 0; m_pc = {jmp_addr[31:2], 2'b00}; end
    end
    // memory side: one pending response, delivered rv_lat cycles after grant
    if (hs) begin mem_pend = 1; mem_cnt = rv_lat; mem_addr = imem.addr; end
    rv_next = 0;
    if (mem_pend) begin
      if (mem_cnt <= 1) begin rv_next = 1; rd_next = mem_word(mem_addr); mem_pend = 0; end
      else mem_cnt--;
    end
  end

  initial begin
    imem.rvalid = 1'b0;
    imem.rdata  = '0;
    forever begin
      @(posedge clk); #1;
      imem.rvalid = rv_next;
      imem.rdata  = rv_next ? rd_next : 32'h0;
    end
  end

  // which: 0 = handshake, 1 = avail, 3 = request high
  task automatic wait_until(input int which, output bit ok);
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if ((which == 0 && imem.req && imem.gnt) || (which == 1 && avail) ||
          (which == 3 && imem.req)) begin
        ok = 1;
        return;
      end
    end
    n_tests++; n_fail++;
    $display("FAIL wait_%0d: condition not seen within 40 cycles", which);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit ok;
    int k;
    rstn = 0; jmp_addr = '0; jmp_valid = 0; en_reg = 1; en_follow = 0;
    gnt_reg = 1; rv_lat = 1; poison_addr = 32'h1;
    repeat (3) @(negedge clk);
    chk("reset_addr_lit", imem.addr, 32'h100);
    chk("reset_req_lit", imem.req, 0);

    // zero-wait fetch from BOOT
    @(posedge clk); #1 rstn = 1;
    @(negedge clk);
    chk("t1_req0", imem.req, 1);
    chk("t1_addr0", imem.addr, 32'h100);
    @(negedge clk);
    chk("t1_avail_n1", avail, 0);
    @(negedge clk);
    chk("t1_avail_n2", avail, 1);
    chk("t1_iaddr0", instr_addr, 32'h100);
    chk("t1_idata0", instr_rdata, 32'hC0DE0100);
    chk("t1_addr1", imem.addr, 32'h104);
    repeat (2) @(negedge clk);
    chk("t1_addr2", imem.addr, 32'h108);
    chk("t1_iaddr1", instr_addr, 32'h104);
    repeat (6) @(negedge clk);

    // decoder stall fills the FIFO, one pop re-enables requests
    @(posedge clk); #1 en_reg = 0;
    repeat (8) @(negedge clk);
    chk("t2_req_full", imem.req, 0);
    chk("t2_avail", avail, 1);
    @(posedge clk); #1 en_reg = 1;
    @(posedge clk); #1 en_reg = 0;
    @(negedge clk);
    chk("t2_req_again", imem.req, 1);
    @(posedge clk); #1 en_reg = 1;
    repeat (4) @(negedge clk);

    // redirect while waiting; late response carries DEADBEEF
    @(posedge clk); #1 rv_lat = 3;
    wait_until(0, ok);
    poison_addr = imem.addr;
    @(posedge clk); #1 jmp_addr = 32'h2003; jmp_valid = 1;
    @(posedge clk); #1 jmp_valid = 0;
    @(negedge clk);
    chk("t3_flushed", avail, 0);
    wait_until(3, ok);
    chk("t3_req_addr", imem.addr, 32'h2000);
    wait_until(1, ok);
    chk("t3_iaddr", instr_addr, 32'h2000);
    chk("t3_idata", instr_rdata, 32'hC0DE2000);
    @(posedge clk); #1 rv_lat = 1;

    // redirect in the grant cycle of 0x40
    @(posedge clk); #1 gnt_reg = 0; jmp_addr = 32'h40; jmp_valid = 1;
    @(posedge clk); #1 jmp_valid = 0;
    wait_until(3, ok);
    chk("t4_pend_addr", imem.addr, 32'h40);
    @(posedge clk); #1 gnt_reg = 1; jmp_addr = 32'h300; jmp_valid = 1;
    @(negedge clk);
    chk("t4_gnt_req", imem.req, 1);
    chk("t4_gnt_addr", imem.addr, 32'h40);
    @(posedge clk); #1 jmp_valid = 0;
    wait_until(1, ok);
    chk("t4_iaddr", instr_addr, 32'h300);
    chk("t4_idata", instr_rdata, 32'hC0DE0300);

    // push and pop together at count 1
    @(posedge clk); #1 en_reg = 0; jmp_addr = 32'h500; jmp_valid = 1;
    @(posedge clk); #1 jmp_valid = 0;
    wait_until(1, ok);
    chk("t5_first", instr_addr, 32'h500);
    @(posedge clk); #1 en_follow = 1;
    k = 0;
    repeat (12) begin
      @(negedge clk);
      chk("t5_avail", avail, 1);
      if (imem.rvalid) k++;
    end
    @(posedge clk); #1 en_follow = 0;
    @(negedge clk);
    chk("t5_pairs", k, 6);
    chk("t5_head", instr_addr, 32'h518);
    @(posedge clk); #1 en_reg = 1;
    repeat (6) @(negedge clk);

    // reset with a response outstanding
    @(posedge clk); #1 rv_lat = 3;
    wait_until(0, ok);
    poison_addr = imem.addr;
    @(posedge clk); #2 rstn = 0; gnt_reg = 0;
    #1;
    chk("t6_req", imem.req, 0);
    chk("t6_avail", avail, 0);
    chk("t6_pc", imem.addr, 32'h100);
    chk("t6_rdata", instr_rdata, 0);
    chk("t6_iaddr", instr_addr, 0);
    @(posedge clk); #1 rstn = 1; rv_lat = 1;
    @(posedge clk);
    @(posedge clk); #1 gnt_reg = 1;
    wait_until(1, ok);
    chk("t6_restart_addr", instr_addr, 32'h100);
    chk("t6_restart_data", instr_rdata, 32'hC0DE0100);
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
